// File: rtl/video_timing.sv
// -----------------------------------------------------------------------------
// video_timing
//
// Raster timing generator and VGA pixel output stage, clocked by the dot clock.
// A horizontal/vertical counter pair walks the raster. The current beam
// coordinate is published to the pixel source, and the source's colour comes
// back PIXEL_LATENCY cycles later. Blanking and sync decodes are delayed by the
// same amount, so one final register stage emits colour and syncs aligned.
//
// Ports:
//   clk          dot clock; all state changes on the rising edge
//   reset        synchronous, active-high; clears counters and the whole pipeline
//   x, y         current horizontal / vertical counter values
//   active       current coordinate lies inside the visible area
//   line_start   high while x==0
//   frame_start  high while x==0 and y==0
//   r_in/g_in/b_in  colour for the coordinate issued PIXEL_LATENCY cycles earlier
//   r, g, b      registered colour, forced to zero outside the visible area
//   hsync, vsync registered syncs; active-low when SYNC_NEG=1
// -----------------------------------------------------------------------------
module video_timing #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int SYNC_NEG      = 1,
  parameter int PIXEL_LATENCY = 1,
  parameter int COORD_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [COORD_WIDTH-1:0] x,
  output logic [COORD_WIDTH-1:0] y,
  output logic                   active,
  output logic                   line_start,
  output logic                   frame_start,
  input  logic [3:0]             r_in,
  input  logic [3:0]             g_in,
  input  logic [3:0]             b_in,
  output logic [3:0]             r,
  output logic [3:0]             g,
  output logic [3:0]             b,
  output logic                   hsync,
  output logic                   vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [COORD_WIDTH-1:0] H_LAST    = COORD_WIDTH'(H_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] V_LAST    = COORD_WIDTH'(V_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] COORD_ONE = COORD_WIDTH'(1);
  localparam logic                   SYNC_OFF  = 1'(SYNC_NEG);

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [COORD_WIDTH-1:0] h_q, h_d;
  logic [COORD_WIDTH-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + COORD_ONE;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + COORD_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign x = h_q;
  assign y = v_q;

  // ---------------------------------------------------------------------------
  // Combinational decodes of the current coordinate
  // ---------------------------------------------------------------------------
  int  h_int, v_int;
  logic hs_raw, vs_raw;

  assign h_int       = int'(h_q);
  assign v_int       = int'(v_q);
  assign active      = (h_int < H_ACTIVE) && (v_int < V_ACTIVE);
  assign line_start  = (h_q == '0);
  assign frame_start = (h_q == '0) && (v_q == '0);
  assign hs_raw      = (h_int >= HS_START) && (h_int < HS_END);
  // Depends on v only, so it can only change together with v at the line wrap.
  assign vs_raw      = (v_int >= VS_START) && (v_int < VS_END);

  // ---------------------------------------------------------------------------
  // Alignment pipeline: {active, hs, vs} delayed to match the pixel source
  // ---------------------------------------------------------------------------
  logic [2:0] stage_in;
  logic [2:0] delayed;

  assign stage_in = {active, hs_raw, vs_raw};

  if (PIXEL_LATENCY == 0) begin : g_direct
    assign delayed = stage_in;
  end else begin : g_pipe
    logic [2:0] pipe_q [PIXEL_LATENCY];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < PIXEL_LATENCY; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= stage_in;
        for (int i = 1; i < PIXEL_LATENCY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign delayed = pipe_q[PIXEL_LATENCY-1];
  end

  logic delayed_active, hs_dly, vs_dly;
  assign delayed_active = delayed[2];
  assign hs_dly         = delayed[1];
  assign vs_dly         = delayed[0];

  // ---------------------------------------------------------------------------
  // Output register: colour masked by the delayed active bit, syncs polarised.
  // The pixel source is never trusted to blank on its own.
  // ---------------------------------------------------------------------------
  logic [3:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic       hsync_q, vsync_q, hsync_d, vsync_d;

  always_comb begin
    r_d     = delayed_active ? r_in : 4'd0;
    g_d     = delayed_active ? g_in : 4'd0;
    b_d     = delayed_active ? b_in : 4'd0;
    hsync_d = hs_dly ^ SYNC_OFF;
    vsync_d = vs_dly ^ SYNC_OFF;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hsync_q <= SYNC_OFF;
      vsync_q <= SYNC_OFF;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign r     = r_q;
  assign g     = g_q;
  assign b     = b_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule
